// File: rtl/pwm_note_sequencer.sv
// pwm_note_sequencer: steps through a table of {duration, period, duty} notes and drives the
// pwm block's {period, duty} configuration word, with a silent gap between notes.
module pwm_note_sequencer #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TICK_DIV  = 50000,
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_wr_en,
    input  logic [$clog2(DEPTH)-1:0] i_wr_addr,
    input  logic [23:0]              i_wr_data,
    input  logic                     i_start,
    input  logic                     i_stop,
    input  logic                     i_loop_en,
    input  logic [$clog2(DEPTH):0]   i_length,
    output logic [15:0]              o_pwm_reg,
    output logic                     o_busy,
    output logic [$clog2(DEPTH)-1:0] o_note_idx,
    output logic                     o_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);
    localparam logic [LW-1:0] LEN_MAX   = LW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StPlay,
        StGap
    } state_e;

    // Registered state
    state_e          r_state;
    logic [23:0]     r_table [DEPTH];
    logic [15:0]     r_pwm_reg;
    logic            r_busy;
    logic [AW-1:0]   r_note_idx;
    logic            r_done;
    logic [LW-1:0]   r_len;
    logic [PW-1:0]   r_presc;
    logic [7:0]      r_dur_cnt;
    logic [GW-1:0]   r_gap_cnt;

    // Next-state values
    state_e          w_state_d;
    logic [15:0]     w_pwm_reg_d;
    logic            w_busy_d;
    logic [AW-1:0]   w_note_idx_d;
    logic            w_done_d;
    logic [LW-1:0]   w_len_d;
    logic [PW-1:0]   w_presc_d;
    logic [7:0]      w_dur_cnt_d;
    logic [GW-1:0]   w_gap_cnt_d;

    logic            w_tick;
    logic            w_advance;
    logic            w_load;
    logic [AW-1:0]   w_load_idx;
    logic [23:0]     w_entry;
    logic [LW-1:0]   w_next_idx_ext;

    assign w_tick         = (r_presc == PRESC_MAX);
    assign w_next_idx_ext = {1'b0, r_note_idx} + LW'(1);

    // Sequencing decisions, then a single shared note-load path used by start, advance and loop.
    always_comb begin
        w_state_d    = r_state;
        w_pwm_reg_d  = r_pwm_reg;
        w_busy_d     = r_busy;
        w_note_idx_d = r_note_idx;
        w_done_d     = 1'b0;
        w_len_d      = r_len;
        w_presc_d    = r_presc;
        w_dur_cnt_d  = r_dur_cnt;
        w_gap_cnt_d  = r_gap_cnt;
        w_advance    = 1'b0;
        w_load       = 1'b0;
        w_load_idx   = '0;
        w_entry      = '0;

        unique case (r_state)
            StIdle: begin
                if (i_start && !i_stop && (i_length != '0)) begin
                    w_len_d    = (i_length > LEN_MAX) ? LEN_MAX : i_length;
                    w_load     = 1'b1;
                    w_load_idx = '0;
                end
            end

            StPlay: begin
                if (i_stop) begin
                    w_state_d   = StIdle;
                    w_pwm_reg_d = '0;
                    w_busy_d    = 1'b0;
                    w_presc_d   = '0;
                end else if (w_tick) begin
                    w_presc_d = '0;
                    if (r_dur_cnt == 8'd1) begin
                        if (GAP_TICKS > 0) begin
                            w_state_d   = StGap;
                            w_pwm_reg_d = '0;
                            w_gap_cnt_d = GAP_INIT;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_dur_cnt_d = r_dur_cnt - 8'd1;
                    end
                end else begin
                    w_presc_d = r_presc + 1'b1;
                end
            end

            StGap: begin
                if (i_stop) begin
                    w_state_d   = StIdle;
                    w_pwm_reg_d = '0;
                    w_busy_d    = 1'b0;
                    w_presc_d   = '0;
                end else if (w_tick) begin
                    w_presc_d = '0;
                    if (r_gap_cnt == GW'(1)) begin
                        w_advance = 1'b1;
                    end else begin
                        w_gap_cnt_d = r_gap_cnt - GW'(1);
                    end
                end else begin
                    w_presc_d = r_presc + 1'b1;
                end
            end

            default: begin
                w_state_d   = StIdle;
                w_pwm_reg_d = '0;
                w_busy_d    = 1'b0;
            end
        endcase

        if (w_advance) begin
            if (w_next_idx_ext < r_len) begin
                w_load     = 1'b1;
                w_load_idx = w_next_idx_ext[AW-1:0];
            end else if (i_loop_en) begin
                w_load     = 1'b1;
                w_load_idx = '0;
            end else begin
                // Natural end: note_idx keeps pointing at the last note played.
                w_state_d   = StIdle;
                w_pwm_reg_d = '0;
                w_busy_d    = 1'b0;
                w_done_d    = 1'b1;
            end
        end

        // Table is read before this edge's write lands, so a same-cycle write sees old data.
        w_entry = r_table[w_load_idx];
        if (w_load) begin
            w_state_d    = StPlay;
            w_busy_d     = 1'b1;
            w_note_idx_d = w_load_idx;
            w_pwm_reg_d  = w_entry[15:0];
            w_dur_cnt_d  = (w_entry[23:16] == 8'd0) ? 8'd1 : w_entry[23:16];
            w_presc_d    = '0;
        end
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= StIdle;
            r_pwm_reg  <= '0;
            r_busy     <= 1'b0;
            r_note_idx <= '0;
            r_done     <= 1'b0;
            r_len      <= '0;
            r_presc    <= '0;
            r_dur_cnt  <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_pwm_reg  <= w_pwm_reg_d;
            r_busy     <= w_busy_d;
            r_note_idx <= w_note_idx_d;
            r_done     <= w_done_d;
            r_len      <= w_len_d;
            r_presc    <= w_presc_d;
            r_dur_cnt  <= w_dur_cnt_d;
            r_gap_cnt  <= w_gap_cnt_d;
        end
    end

    // Note table: writable in any state, cleared to silence on reset.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_table[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_pwm_reg  = r_pwm_reg;
    assign o_busy     = r_busy;
    assign o_note_idx = r_note_idx;
    assign o_done     = r_done;

endmodule

// File: tb/tb_pwm_note_sequencer.sv
// Bench for pwm_note_sequencer: every-cycle comparison against a clock-counting note model,
// plus literal spot checks from hand-worked timelines (TICK_DIV=4, GAP_TICKS=1, DEPTH=16).
module tb_pwm_note_sequencer;

    localparam int DEPTH     = 16;
    localparam int TICK_DIV  = 4;
    localparam int GAP_TICKS = 1;
    localparam int MAXK      = 200;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        wr_en   = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [23:0] wr_data = '0;
    logic        start   = 1'b0;
    logic        stop    = 1'b0;
    logic        loop_en = 1'b0;
    logic [4:0]  length  = '0;
    logic [15:0] o_pwm_reg;
    logic        o_busy;
    logic [3:0]  o_note_idx;
    logic        o_done;

    int n_cmp = 0;
    int n_bad = 0;

    pwm_note_sequencer #(
        .DEPTH    (DEPTH),
        .TICK_DIV (TICK_DIV),
        .GAP_TICKS(GAP_TICKS)
    ) dut (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_start   (start),
        .i_stop    (stop),
        .i_loop_en (loop_en),
        .i_length  (length),
        .o_pwm_reg (o_pwm_reg),
        .o_busy    (o_busy),
        .o_note_idx(o_note_idx),
        .o_done    (o_done)
    );

    initial begin
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- Model: each note/gap is a run of clocks counted down directly ----------
    logic [23:0] m_table [DEPTH];
    logic [15:0] m_pwm;
    logic        m_busy;
    logic        m_done;
    int          m_idx;
    int          m_remain;
    int          m_len;
    bit          m_in_gap;

    task automatic m_load(input int idx);
        logic [7:0] dur;
        m_idx    = idx;
        m_pwm    = m_table[idx][15:0];
        dur      = m_table[idx][23:16];
        m_remain = ((dur == 8'd0) ? 1 : int'(dur)) * TICK_DIV;
        m_in_gap = 1'b0;
        m_busy   = 1'b1;
    endtask

    task automatic m_reset();
        m_pwm = '0; m_busy = 1'b0; m_done = 1'b0; m_idx = 0;
        m_remain = 0; m_len = 0; m_in_gap = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_table[i] = '0;
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_reset();
            end else begin
                m_done = 1'b0;
                if (!m_busy) begin
                    if (start && !stop && length != 0) begin
                        m_len = (int'(length) > DEPTH) ? DEPTH : int'(length);
                        m_load(0);
                    end
                end else if (stop) begin
                    m_busy = 1'b0;
                    m_pwm  = '0;
                end else begin
                    m_remain--;
                    if (m_remain == 0) begin
                        if (!m_in_gap && GAP_TICKS > 0) begin
                            m_in_gap = 1'b1;
                            m_pwm    = '0;
                            m_remain = GAP_TICKS * TICK_DIV;
                        end else if (m_idx + 1 < m_len) begin
                            m_load(m_idx + 1);
                        end else if (loop_en) begin
                            m_load(0);
                        end else begin
                            m_busy = 1'b0;
                            m_pwm  = '0;
                            m_done = 1'b1;
                        end
                    end
                end
                if (wr_en) m_table[wr_addr] = wr_data;
            end
        end
    end

    // ---------------- Per-cycle compare against the model ----------------
    initial begin
        forever begin
            @(negedge clk);
            check($sformatf("pwm_reg@%0t", $time), 32'(o_pwm_reg), 32'(m_pwm));
            check($sformatf("busy@%0t", $time), 32'(o_busy), 32'(m_busy));
            check($sformatf("note_idx@%0t", $time), 32'(o_note_idx), 32'(m_idx));
            check($sformatf("done@%0t", $time), 32'(o_done), 32'(m_done));
        end
    end

    // ---------------- Stimulus helpers ----------------
    logic [15:0] tr_pwm  [0:MAXK];
    logic        tr_busy [0:MAXK];
    logic [3:0]  tr_idx  [0:MAXK];
    logic        tr_done [0:MAXK];
    int          tr_ndone;

    task automatic wr(input logic [3:0] a, input logic [23:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Caller raises start at k=0; trace index k counts negedges after that.
    task automatic capture(input int n, input int loop_off_k, input int stop_k,
                           input int wr_k, input logic [3:0] a, input logic [23:0] d);
        tr_ndone = 0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            tr_pwm[k]  = o_pwm_reg;
            tr_busy[k] = o_busy;
            tr_idx[k]  = o_note_idx;
            tr_done[k] = o_done;
            if (o_done) tr_ndone++;
            if (k == 1) start = 1'b0;
            if (k == loop_off_k) loop_en = 1'b0;
            if (k == stop_k) stop = 1'b1;
            if (k == stop_k + 1) stop = 1'b0;
            if (k == wr_k) begin
                wr_en = 1'b1; wr_addr = a; wr_data = d;
            end
            if (k == wr_k + 1) wr_en = 1'b0;
        end
    endtask

    int cnt_note;
    int cnt_gap;
    int done_k;
    int busy_sum;

    // ---------------- Directed tests ----------------
    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_pwm", 32'(o_pwm_reg), 32'h0);
        check("reset_busy", 32'(o_busy), 32'h0);
        check("reset_idx", 32'(o_note_idx), 32'h0);
        check("reset_done", 32'(o_done), 32'h0);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // 1. Reset while playing, then confirm the table reads back silent
        wr(4'd0, 24'h028040);
        start = 1'b1; length = 5'd1;
        capture(3, -1, -1, -1, 4'd0, 24'h0);
        check("t1_playing", 32'(tr_pwm[2]), 32'h8040);
        #2 rst_n = 1'b0;
        @(negedge clk);
        check("t1_rst_pwm", 32'(o_pwm_reg), 32'h0);
        check("t1_rst_busy", 32'(o_busy), 32'h0);
        check("t1_rst_done", 32'(o_done), 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1; length = 5'd1;
        capture(10, -1, -1, -1, 4'd0, 24'h0);
        check("t1_silent_pwm", 32'(tr_pwm[1]), 32'h0);
        check("t1_silent_busy", 32'(tr_busy[1]), 32'h1);
        check("t1_silent_busy_end", 32'(tr_busy[8]), 32'h1);
        check("t1_silent_done", 32'(tr_done[9]), 32'h1);
        check("t1_ndone", 32'(tr_ndone), 32'd1);

        // 2. Single note
        wr(4'd0, 24'h028040);
        start = 1'b1; length = 5'd1;
        capture(15, -1, -1, -1, 4'd0, 24'h0);
        cnt_note = 0; cnt_gap = 0; done_k = 0;
        for (int k = 1; k <= 15; k++) begin
            if (tr_pwm[k] == 16'h8040) cnt_note++;
            if (tr_busy[k] && tr_pwm[k] == 16'h0) cnt_gap++;
            if (tr_done[k] && done_k == 0) done_k = k;
        end
        check("t2_first", 32'(tr_pwm[1]), 32'h8040);
        check("t2_note_clks", 32'(cnt_note), 32'd8);
        check("t2_gap_clks", 32'(cnt_gap), 32'd4);
        check("t2_done_k", 32'(done_k), 32'd13);
        check("t2_busy_end", 32'(tr_busy[13]), 32'h0);
        check("t2_ndone", 32'(tr_ndone), 32'd1);

        // 3. Three-note sequence
        wr(4'd0, 24'h011008);
        wr(4'd1, 24'h032010);
        wr(4'd2, 24'h003018);
        start = 1'b1; length = 5'd3;
        capture(35, -1, -1, -1, 4'd0, 24'h0);
        check("t3_n0_a", 32'(tr_pwm[1]), 32'h1008);
        check("t3_n0_b", 32'(tr_pwm[4]), 32'h1008);
        check("t3_gap0", 32'(tr_pwm[5]), 32'h0);
        check("t3_n1_a", 32'(tr_pwm[9]), 32'h2010);
        check("t3_n1_b", 32'(tr_pwm[20]), 32'h2010);
        check("t3_gap1", 32'(tr_pwm[21]), 32'h0);
        check("t3_n2_a", 32'(tr_pwm[25]), 32'h3018);
        check("t3_n2_b", 32'(tr_pwm[28]), 32'h3018);
        check("t3_gap2", 32'(tr_pwm[29]), 32'h0);
        check("t3_idx1", 32'(tr_idx[9]), 32'd1);
        check("t3_idx2", 32'(tr_idx[25]), 32'd2);
        check("t3_done", 32'(tr_done[33]), 32'h1);
        check("t3_idx_end", 32'(tr_idx[33]), 32'd2);
        check("t3_ndone", 32'(tr_ndone), 32'd1);

        // 4. Loop mode, loop_en dropped during the final note of the second pass
        loop_en = 1'b1;
        start = 1'b1; length = 5'd3;
        capture(68, 58, -1, -1, 4'd0, 24'h0);
        check("t4_wrap_pwm", 32'(tr_pwm[33]), 32'h1008);
        check("t4_wrap_idx", 32'(tr_idx[33]), 32'd0);
        check("t4_wrap_nodone", 32'(tr_done[33]), 32'h0);
        check("t4_wrap_busy", 32'(tr_busy[33]), 32'h1);
        check("t4_pass2_n1", 32'(tr_pwm[41]), 32'h2010);
        check("t4_done", 32'(tr_done[65]), 32'h1);
        check("t4_busy_end", 32'(tr_busy[65]), 32'h0);
        check("t4_ndone", 32'(tr_ndone), 32'd1);

        // 5a. Stop in the middle of note index 1
        start = 1'b1; length = 5'd3;
        capture(24, -1, 12, -1, 4'd0, 24'h0);
        check("t5_before_stop", 32'(tr_pwm[12]), 32'h2010);
        check("t5_stop_pwm", 32'(tr_pwm[13]), 32'h0);
        check("t5_stop_busy", 32'(tr_busy[13]), 32'h0);
        check("t5_stop_idx", 32'(tr_idx[13]), 32'd1);
        check("t5_stop_nodone", 32'(tr_ndone), 32'd0);

        // 5b. start and stop together while idle
        start = 1'b1; stop = 1'b1; length = 5'd3;
        capture(6, -1, 0, -1, 4'd0, 24'h0);
        busy_sum = 0;
        for (int k = 1; k <= 6; k++) busy_sum += int'(tr_busy[k]);
        check("t5_startstop_busy", 32'(busy_sum), 32'd0);

        // length=0 start is ignored
        start = 1'b1; length = 5'd0;
        capture(5, -1, -1, -1, 4'd0, 24'h0);
        busy_sum = 0;
        for (int k = 1; k <= 5; k++) busy_sum += int'(tr_busy[k]);
        check("len0_busy", 32'(busy_sum), 32'd0);
        check("len0_ndone", 32'(tr_ndone), 32'd0);

        // 6a. Rewrite entry 1 while note 0 plays
        start = 1'b1; length = 5'd3;
        capture(26, -1, -1, 2, 4'd1, 24'h015522);
        check("t6_new_n1", 32'(tr_pwm[9]), 32'h5522);
        check("t6_gap1", 32'(tr_pwm[13]), 32'h0);
        check("t6_n2", 32'(tr_pwm[17]), 32'h3018);
        check("t6_done", 32'(tr_done[25]), 32'h1);

        // 6b. Write to entry 1 on the very edge that loads it: old data plays
        start = 1'b1; length = 5'd3;
        capture(26, -1, -1, 8, 4'd1, 24'h01AAAA);
        check("t6_old_data", 32'(tr_pwm[9]), 32'h5522);
        check("t6b_done", 32'(tr_done[25]), 32'h1);

        // 6c. length=20 clamps to 16 notes
        for (int i = 0; i < DEPTH; i++) begin
            wr(4'(i), {8'd1, 8'(i + 1), 8'(i)});
        end
        start = 1'b1; length = 5'd20;
        capture(132, -1, -1, -1, 4'd0, 24'h0);
        check("t6_clamp_first", 32'(tr_pwm[1]), 32'h0100);
        check("t6_clamp_last_idx", 32'(tr_idx[121]), 32'd15);
        check("t6_clamp_last_pwm", 32'(tr_pwm[121]), 32'h100F);
        check("t6_clamp_busy", 32'(tr_busy[128]), 32'h1);
        check("t6_clamp_done", 32'(tr_done[129]), 32'h1);
        check("t6_clamp_ndone", 32'(tr_ndone), 32'd1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
